ama_riscv_dmem_responder: RTL and testbench
===========================================

// Module: ama_riscv_dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the core's dmem request interface.
//  Accepts one request per handshake: store with byte mask, or load with funct3 width.
//  Stores commit byte lanes into a synchronous word array.
//  Loads return data shifted to bit 0 and sign/zero-extended, with programmable wait states.
//  Replaces the bare dmem array behind the MEM stage.
// PARAMETERS
//  ADDR_W    14  word-address bits; depth = 2**ADDR_W 32-bit words
//  WAIT_CYC  0   extra wait cycles per request (0..15); latency = 1+WAIT_CYC
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous reset, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; handshake = req_valid & req_ready
//  req_addr    in   32  byte address
//  req_we      in   4   byte write-enable mask; nonzero = store, 0 = load
//  req_wdata   in   32  store data, already lane-aligned
//  req_funct3  in   3   load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  rsp_valid   out  1   one-cycle response strobe
//  rsp_rdata   out  32  aligned, extended load data; 0 for stores and errors
//  rsp_err     out  1   request rejected (misaligned / illegal / out of range)
// BEHAVIOUR
//  Reset (rst=0): state IDLE, wait counter 0.
//   Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
//   Array contents are not reset.
//  req_ready = rst & (state==IDLE | state==RESP). Combinational from state only.
//  FSM IDLE/WAIT/RESP:
//   IDLE --accept--> WAIT if WAIT_CYC>0, else RESP.
//   WAIT: counter counts up; at count WAIT_CYC-1, go to RESP.
//   RESP: rsp_valid=1 for exactly one cycle.
//    On accept in RESP: go to WAIT or RESP (back-to-back allowed).
//    Otherwise: go to IDLE.
//  WAIT_CYC=0: one request per cycle sustained. rsp_valid follows each accept by 1 cycle.
//  Accept edge does:
//   - Legality check.
//   - Store: byte write into the array, per req_we bit.
//   - Load: word read into a holding register.
//   - Latch funct3, addr[1:0], err.
//  Response values are held stable until the next response.
//  Legal checks:
//   - req_addr[31:ADDR_W+2] must be 0.
//   - Store masks allowed: 0001/0010/0100/1000, 0011/1100, 1111.
//   - Load: funct3 in the listed set.
//   - Load LH/LHU needs addr[0]=0; LW needs addr[1:0]=00.
//  Illegal request: no array write; response has rsp_err=1, rsp_rdata=0. Latency unchanged.
//  Load formatting (offset o = addr[1:0]):
//   - Byte: word[8o+7:8o], extended from bit 7 (LB) or zero (LBU).
//   - Half: word[16(o/2)+15:16(o/2)], extended from bit 15 (LH) or zero (LHU).
//   - LW: whole word.
//  Store response: rsp_valid=1, rsp_err=0, rsp_rdata=0.
//  Read-after-write: a load accepted the cycle after a store to the same word sees new bytes.
//  req_valid ignored while req_ready=0. No request is queued, no request is lost.
//   Initiator holds its request.
//  Reset mid-operation: pending response is discarded (no rsp_valid).
//   A store already committed at its accept edge remains in the array.
// TESTING
//  1. WAIT_CYC=0: SW 0x8000_00F0 to addr 0x100, mask 1111. Next cycle LW 0x100.
//     -> rsp_valid on cycles T+1 and T+2; rdata 0, then 0x8000_00F0.
//  2. After test 1, LB @0x103 -> 0xFFFF_FF80. LBU @0x103 -> 0x0000_0080.
//     LH @0x102 -> 0xFFFF_8000. LHU @0x100 -> 0x0000_00F0.
//  3. SB mask 0100, wdata 0x00AB_0000 to 0x100. Then LW 0x100.
//     -> 0x80AB_00F0; other bytes unchanged.
//  4. Illegal requests, each -> rsp_err=1, rdata 0, array unchanged on readback:
//     LW @0x102; LH @0x103; mask 0110; funct3 011; addr bit ADDR_W+2 set.
//  5. WAIT_CYC=3: request held valid for 3 cycles.
//     -> req_ready low 3 cycles; rsp_valid at accept+4 with ready high.
//     Back-to-back request accepted in RESP cycle.
//  6. WAIT_CYC=3: assert rst=0 in WAIT after a store accept.
//     -> no rsp_valid; all outputs 0 immediately.
//     After release: load returns the stored word.

Source files
------------

// File: rtl/ama_riscv_dmem_responder.sv
// ama_riscv_dmem_responder
//   Data-memory responder sitting behind the core's MEM stage. It accepts one
//   request per handshake. A request is either a store with a byte mask or a
//   load with a funct3 width. Stores commit byte lanes into a synchronous word
//   array. Loads return data shifted down to bit 0 and sign- or zero-extended.
//   Every response arrives 1+WAIT_CYC cycles after its accept edge.
//
//   Handshake: a request transfers on a rising edge where req_valid & req_ready.
//   req_ready is a function of rst and state only. The initiator holds its
//   request until it is accepted. rsp_valid is a one-cycle strobe, and
//   rsp_rdata/rsp_err stay stable until the next strobe.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active-low
//   req_valid    request present
//   req_ready    responder can accept this cycle
//   req_addr     byte address
//   req_we       byte write mask (nonzero = store, zero = load)
//   req_wdata    lane-aligned store data
//   req_funct3   load width (LB/LH/LW/LBU/LHU)
//   rsp_valid    one-cycle response strobe
//   rsp_rdata    aligned, extended load data (0 for stores and errors)
//   rsp_err      request was rejected
//   dbg_state    current FSM state, for observation only
module ama_riscv_dmem_responder #(
   parameter int ADDR_W   = 14,
   parameter int WAIT_CYC = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam state_t AFTER_ACCEPT = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   // Request attributes latched at the accept edge
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        err_q;
   logic        load_q;
   logic [31:0] word_q;

   // Copy of the last response, shown outside the RESP cycle
   logic [31:0] rdata_hold_q;
   logic        err_hold_q;

   logic [31:0] mem [DEPTH];

   logic              accept;
   logic              is_store;
   logic              addr_ok;
   logic              mask_ok;
   logic              load_ok;
   logic              req_legal;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       fmt_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   assign req_ready = rst & ((state_q == ST_IDLE) | (state_q == ST_RESP));
   assign accept    = req_valid & req_ready;
   assign is_store  = |req_we;
   assign addr_ok   = (req_addr[31:ADDR_W+2] == '0);
   assign idx       = req_addr[ADDR_W+1:2];

   always_comb begin
      mask_ok = 1'b0;
      case (req_we)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
         default:                   mask_ok = 1'b0;
      endcase
   end

   always_comb begin
      load_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: load_ok = 1'b1;
         3'b001, 3'b101: load_ok = ~req_addr[0];
         3'b010:         load_ok = (req_addr[1:0] == 2'b00);
         default:        load_ok = 1'b0;
      endcase
   end

   assign req_legal = addr_ok & (is_store ? mask_ok : load_ok);
   assign wr_en     = accept & is_store & req_legal;
   assign rd_en     = accept & ~is_store & req_legal;

   // The array has no reset. A load accepted the cycle after a store reads the
   // word after that store's edge has already committed it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (req_we[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
      if (rd_en) word_q <= mem[idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         f3_q         <= 3'd0;
         off_q        <= 2'd0;
         err_q        <= 1'b0;
         load_q       <= 1'b0;
         rdata_hold_q <= 32'd0;
         err_hold_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            f3_q   <= req_funct3;
            off_q  <= req_addr[1:0];
            err_q  <= ~req_legal;
            load_q <= ~is_store & req_legal;
         end
         if (state_q == ST_RESP) begin
            rdata_hold_q <= fmt_data;
            err_hold_q   <= err_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = AFTER_ACCEPT;
               cnt_d   = 4'd0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            if (accept) begin
               state_d = AFTER_ACCEPT;
               cnt_d   = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Load formatting from the held word. Stores and rejected requests give 0.
   assign byte_sel = word_q[8*off_q +: 8];
   assign half_sel = off_q[1] ? word_q[31:16] : word_q[15:0];

   always_comb begin
      fmt_data = 32'd0;
      if (load_q) begin
         case (f3_q)
            3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  fmt_data = word_q;
            3'b100:  fmt_data = {24'd0, byte_sel};
            3'b101:  fmt_data = {16'd0, half_sel};
            default: fmt_data = 32'd0;
         endcase
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = (state_q == ST_RESP) ? fmt_data : rdata_hold_q;
   assign rsp_err   = (state_q == ST_RESP) ? err_q : err_hold_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ama_riscv_dmem_responder.sv
module tb_ama_riscv_dmem_responder;

  logic clk;

  // DUT a: WAIT_CYC = 0
  logic        a_rst, a_valid, a_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_addr, a_wdata, a_rsp_rdata;
  logic [3:0]  a_we;
  logic [2:0]  a_f3;
  logic [1:0]  a_state;

  // DUT b: WAIT_CYC = 3
  logic        b_rst, b_valid, b_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rsp_rdata;
  logic [3:0]  b_we;
  logic [2:0]  b_f3;
  logic [1:0]  b_state;

  int tests = 0;
  int fails = 0;

  logic [31:0] a_exp_q[$];
  logic        a_exp_err_q[$];
  logic [31:0] b_exp_q[$];
  logic        b_exp_err_q[$];

  ama_riscv_dmem_responder #(.ADDR_W(14), .WAIT_CYC(0)) u_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_addr(a_addr), .req_we(a_we), .req_wdata(a_wdata), .req_funct3(a_f3),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .dbg_state(a_state)
  );

  ama_riscv_dmem_responder #(.ADDR_W(14), .WAIT_CYC(3)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_addr(b_addr), .req_we(b_we), .req_wdata(b_wdata), .req_funct3(b_f3),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .dbg_state(b_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present a request, hold it until ready, push the expected response,
  // return 1 time unit after the accepting edge with valid dropped
  task automatic send(input bit sel, input logic [31:0] addr, input logic [3:0] we,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] ed, input logic ee);
    int n;
    n = 0;
    if (!sel) begin
      a_valid = 1'b1; a_addr = addr; a_we = we; a_wdata = wd; a_f3 = f3;
    end else begin
      b_valid = 1'b1; b_addr = addr; b_we = we; b_wdata = wd; b_f3 = f3;
    end
    @(negedge clk);
    while (((sel ? b_ready : a_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "b_accept" : "a_accept", {31'd0, (sel ? b_ready : a_ready)}, 32'd1);
    if (!sel) begin
      a_exp_q.push_back(ed); a_exp_err_q.push_back(ee);
    end else begin
      b_exp_q.push_back(ed); b_exp_err_q.push_back(ee);
    end
    @(posedge clk); #1;
    if (!sel) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? b_exp_q.size() : a_exp_q.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "b_drain" : "a_drain", 32'(sel ? b_exp_q.size() : a_exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // scoreboards
  always @(negedge clk) begin
    logic [31:0] ed;
    logic        ee;
    if (a_rsp_valid === 1'b1) begin
      if (a_exp_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL a_unexpected_rsp observed rdata=%h expected no response", a_rsp_rdata);
      end else begin
        ed = a_exp_q.pop_front();
        ee = a_exp_err_q.pop_front();
        chk("a_rsp_rdata", a_rsp_rdata, ed);
        chk("a_rsp_err", {31'd0, a_rsp_err}, {31'd0, ee});
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ed;
    logic        ee;
    if (b_rsp_valid === 1'b1) begin
      if (b_exp_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL b_unexpected_rsp observed rdata=%h expected no response", b_rsp_rdata);
      end else begin
        ed = b_exp_q.pop_front();
        ee = b_exp_err_q.pop_front();
        chk("b_rsp_rdata", b_rsp_rdata, ed);
        chk("b_rsp_err", {31'd0, b_rsp_err}, {31'd0, ee});
      end
    end
  end

  initial begin
    a_rst = 1'b0; a_valid = 1'b0; a_addr = '0; a_we = '0; a_wdata = '0; a_f3 = '0;
    b_rst = 1'b0; b_valid = 1'b0; b_addr = '0; b_we = '0; b_wdata = '0; b_f3 = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_a_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_a_rdata", a_rsp_rdata, 32'd0);
    chk("rst_a_err", {31'd0, a_rsp_err}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_b_valid", {31'd0, b_rsp_valid}, 32'd0);
    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_a_ready", {31'd0, a_ready}, 32'd1);

    // 1: SW then LW back-to-back, responses on the two following cycles
    send(0, 32'h100, 4'b1111, 32'h8000_00F0, 3'b010, 32'h0, 1'b0);
    chk("t1_sw_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("t1_sw_rdata", a_rsp_rdata, 32'd0);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b010, 32'h8000_00F0, 1'b0);
    chk("t1_lw_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("t1_lw_rdata", a_rsp_rdata, 32'h8000_00F0);
    @(posedge clk); #1;
    chk("t1_strobe_end", {31'd0, a_rsp_valid}, 32'd0);
    chk("t1_rdata_held", a_rsp_rdata, 32'h8000_00F0);

    // 2: load widths and extension
    send(0, 32'h103, 4'b0000, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0);
    send(0, 32'h103, 4'b0000, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
    send(0, 32'h102, 4'b0000, 32'h0, 3'b001, 32'hFFFF_8000, 1'b0);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b101, 32'h0000_00F0, 1'b0);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b000, 32'hFFFF_FFF0, 1'b0);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b001, 32'h0000_00F0, 1'b0);

    // 3: single-byte store into lane 2
    send(0, 32'h100, 4'b0100, 32'h00AB_0000, 3'b010, 32'h0, 1'b0);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b010, 32'h80AB_00F0, 1'b0);
    send(0, 32'h102, 4'b0000, 32'h0, 3'b000, 32'hFFFF_FFAB, 1'b0);
    // halfword store into upper lanes
    send(0, 32'h104, 4'b1111, 32'h1122_3344, 3'b010, 32'h0, 1'b0);
    send(0, 32'h104, 4'b1100, 32'h7FEE_0000, 3'b010, 32'h0, 1'b0);
    send(0, 32'h104, 4'b0000, 32'h0, 3'b010, 32'h7FEE_3344, 1'b0);

    // 4: illegal requests, then readback unchanged
    send(0, 32'h102, 4'b0000, 32'h0, 3'b010, 32'h0, 1'b1);
    send(0, 32'h103, 4'b0000, 32'h0, 3'b001, 32'h0, 1'b1);
    send(0, 32'h100, 4'b0110, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b011, 32'h0, 1'b1);
    send(0, 32'h0001_0100, 4'b0000, 32'h0, 3'b010, 32'h0, 1'b1);
    send(0, 32'h0001_0100, 4'b1111, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b1);
    send(0, 32'h100, 4'b0000, 32'h0, 3'b010, 32'h80AB_00F0, 1'b0);
    wait_drain(0);

    // 5: WAIT_CYC=3, request held during the wait, accepted in RESP
    send(1, 32'h200, 4'b1111, 32'h1234_5678, 3'b010, 32'h0, 1'b0);
    b_valid = 1'b1; b_addr = 32'h200; b_we = 4'b0000; b_wdata = 32'h0; b_f3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      chk("t5_wait_ready", {31'd0, b_ready}, 32'd0);
      chk("t5_wait_valid", {31'd0, b_rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("t5_resp_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("t5_resp_ready", {31'd0, b_ready}, 32'd1);
    b_exp_q.push_back(32'h1234_5678); b_exp_err_q.push_back(1'b0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_b2b_wait_valid", {31'd0, b_rsp_valid}, 32'd0);
      chk("t5_b2b_rdata_held", b_rsp_rdata, 32'd0);
      @(posedge clk); #1;
    end
    chk("t5_b2b_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("t5_b2b_rdata", b_rsp_rdata, 32'h1234_5678);
    wait_drain(1);

    // 6: reset during WAIT after a store accept
    send(1, 32'h204, 4'b1111, 32'hCAFE_BABE, 3'b010, 32'h0, 1'b0);
    #2;
    b_rst = 1'b0;
    #1;
    b_exp_q.delete(); b_exp_err_q.delete();
    chk("t6_rst_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("t6_rst_rdata", b_rsp_rdata, 32'd0);
    chk("t6_rst_err", {31'd0, b_rsp_err}, 32'd0);
    chk("t6_rst_ready", {31'd0, b_ready}, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    b_rst = 1'b1;
    @(posedge clk); #1;
    send(1, 32'h204, 4'b0000, 32'h0, 3'b010, 32'hCAFE_BABE, 1'b0);
    wait_drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
